// File: rtl/reg_write_arbiter_if.sv
// Two-requester register-write request bundle: valid/addr/data toward the
// arbiter, ready back to each requester.
interface reg_write_arbiter_if;
  logic       req0_valid;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Arbitrates two register-write requesters into one commit stage that updates
// five 8-bit configuration registers and tracks writes to unmapped addresses.
//
// state    | meaning
// ST_EMPTY | no accepted write waiting in the commit stage
// ST_FULL  | stage holds a write accepted last cycle; it commits this cycle
module reg_write_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input  logic                      m_clk,
  input  logic                      rst_n,
  reg_write_arbiter_if.slave        bus,
  input  logic                      clr_err,
  output logic [7:0]                reg_0,
  output logic [7:0]                reg_1,
  output logic [7:0]                reg_2,
  output logic [7:0]                reg_3,
  output logic [7:0]                reg_4,
  output logic                      wr_done,
  output logic                      wr_src,
  output logic                      err_flag,
  output logic [3:0]                err_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  stage_state_t    state_q, state_d;
  logic [6:0]      stage_addr_q;
  logic [7:0]      stage_data_q;
  logic            stage_src_q;
  logic            last_gnt_q;
  logic [4:0][7:0] cfg_q;
  logic [4:0][7:0] cfg_view;
  logic            err_flag_q;
  logic [3:0]      err_cnt_q;

  logic            gnt0, gnt1, transfer;
  logic            commit, bad_commit;

  // last_gnt_q = 1 means port 1 won most recently, so port 0 wins next tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if ((RR_EN != 0) && !last_gnt_q) gnt1 = 1'b1;
        else                             gnt0 = 1'b1;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign transfer       = gnt0 | gnt1;

  always_ff @(posedge m_clk) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // A commit is suppressed while reset is low so a staged write is dropped.
  always_comb begin
    state_d    = ST_EMPTY;
    commit     = 1'b0;
    bad_commit = 1'b0;
    if (transfer) state_d = ST_FULL;
    if ((state_q == ST_FULL) && rst_n) begin
      commit     = 1'b1;
      bad_commit = (stage_addr_q > 7'd4);
    end
  end

  always_ff @(posedge m_clk) begin
    if (!rst_n) begin
      stage_addr_q <= 7'd0;
      stage_data_q <= 8'h00;
      stage_src_q  <= 1'b0;
      last_gnt_q   <= 1'b1;
    end else if (transfer) begin
      stage_addr_q <= gnt1 ? bus.req1_addr : bus.req0_addr;
      stage_data_q <= gnt1 ? bus.req1_data : bus.req0_data;
      stage_src_q  <= gnt1;
      last_gnt_q   <= gnt1;
    end
  end

  always_ff @(posedge m_clk) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (commit && (stage_addr_q == 7'(k))) cfg_q[k] <= stage_data_q;
      end
    end
  end

  // A bad-address commit in the same cycle as clr_err restarts the count at 1.
  always_ff @(posedge m_clk) begin
    if (!rst_n) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= 4'd0;
    end else if (bad_commit) begin
      err_flag_q <= 1'b1;
      if (clr_err)                err_cnt_q <= 4'd1;
      else if (err_cnt_q != 4'hF) err_cnt_q <= err_cnt_q + 4'd1;
    end else if (clr_err) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= 4'd0;
    end
  end

  // Register outputs show the committing write during its commit cycle.
  always_comb begin
    cfg_view = cfg_q;
    for (int k = 0; k < 5; k++) begin
      if (commit && (stage_addr_q == 7'(k))) cfg_view[k] = stage_data_q;
    end
  end

  assign reg_0    = cfg_view[0];
  assign reg_1    = cfg_view[1];
  assign reg_2    = cfg_view[2];
  assign reg_3    = cfg_view[3];
  assign reg_4    = cfg_view[4];
  assign wr_done  = commit;
  assign wr_src   = commit & stage_src_q;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL provide parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with port 0 highest.
REQ-002 SHALL provide port m_clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous, active-low; sampled on the m_clk rising edge.
REQ-004 SHALL provide ports req0_valid / req1_valid  input  1 each  requester has a write pending.
REQ-005 SHALL provide ports req0_addr / req1_addr  input  7 each  target register address.
REQ-006 SHALL provide ports req0_data / req1_data  input  8 each  write data.
REQ-007 SHALL provide ports req0_ready / req1_ready  output  1 each  write accepted this cycle.
REQ-008 SHALL provide port clr_err  input  1  clears err_flag and err_cnt.
REQ-009 SHALL provide ports reg_0 .. reg_4  output  8 each  configuration register contents.
REQ-010 SHALL provide port wr_done  output  1  one-cycle pulse when a stage commit occurs.
REQ-011 SHALL provide port wr_src  output  1  source port of the commit flagged by wr_done.
REQ-012 SHALL provide ports err_flag (1) and err_cnt (4)  outputs  sticky bad-address flag and saturating reject count.

Function
REQ-013 SHALL define a transfer on port n as reqn_valid && reqn_ready in the same cycle.
REQ-014 SHALL assert reqn_ready only while reqn_valid is high; at most one ready high per cycle; ready is combinational from valids and the priority pointer.
REQ-015 SHALL grant the sole valid port when exactly one valid is high; SHALL grant no port when none is valid.
REQ-016 With both valids high: RR_EN=1 SHALL grant the port not granted in the most recent transfer; RR_EN=0 SHALL grant port 0.
REQ-017 SHALL update the priority pointer (last-granted port) only on a transfer.
REQ-018 SHALL capture addr, data and source of a transfer into a single commit stage at the end of the transfer cycle N.
REQ-019 SHALL, in cycle N+1, write stage data to reg_<addr> for addr 0..4 and drive wr_done=1 with wr_src=source for exactly that cycle.
REQ-020 SHALL sustain one transfer per cycle; the stage is overwritten each cycle it commits, with no back-pressure.
REQ-021 SHALL, for stage addr > 4, leave reg_0..reg_4 unchanged, still pulse wr_done, set err_flag, and increment err_cnt saturating at 15.
REQ-022 SHALL clear err_flag and err_cnt on clr_err=1 unless an addr > 4 commit occurs in the same cycle; then err_flag=1 and err_cnt=1.
REQ-023 SHALL hold wr_done=0 and all registers unchanged in any cycle with no stage commit.
REQ-024 SHALL not consume a requester's valid on a cycle it is not granted; the losing requester retries the same transfer next cycle.

Reset
REQ-025 SHALL, on rst_n=0 at a rising edge, set reg_0..reg_4=8'h00, stage empty, wr_done=0, wr_src=0, err_flag=0, err_cnt=0, pointer=1 (port 0 wins the first contention).
REQ-026 SHALL drop a write held in the stage when reset is asserted; no register update and no wr_done for it.
REQ-027 SHALL force req0_ready=req1_ready=0 during any cycle rst_n=0 is sampled low.

Verification
REQ-028 Reset then req0 write addr 2 data 8'hA5 -> req0_ready=1 in cycle N; reg_2=8'hA5, wr_done=1, wr_src=0 in cycle N+1.
REQ-029 RR_EN=1, both ports valid for 4 cycles (addr 0 vs addr 1, varied data) -> grants 0,1,0,1; wr_src 0,1,0,1; back-to-back wr_done.
REQ-030 RR_EN=0, both ports valid for 3 cycles -> port 0 granted every cycle; req1_ready stays 0.
REQ-031 req1 write addr 7'h05 data 8'hFF -> registers unchanged, wr_done=1, err_flag=1, err_cnt=1; 16 more bad writes -> err_cnt=15; clr_err -> 0.
REQ-032 Transfer addr 4 data 8'h3C, rst_n=0 the next cycle -> reg_4=8'h00, wr_done=0, pointer=1.
